// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the writeback select codes, the buffered request type and the pipeline value mux.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // Select code 3 is reserved and decodes like ALU.
  function automatic logic [31:0] wb_pipe_value(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [31:0] pc
  );
    logic [31:0] val;
    case (sel)
      WB_SEL_MEM: val = mem;
      WB_SEL_PC4: val = pc + 32'd4;
      default:    val = alu;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t; head is valid combinationally whenever not empty.
// Push when full and pop when empty are ignored; the caller guards with full/empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_dat,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single RF write port shared by the WB stage (priority) and a FIFO of long-latency results;
// a starvation counter forces a one-cycle pipe_stall to drain. Define WB_BYPASS_EN for same-cycle ll writes.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wb_valid,
  input  logic [4:0]               pipe_rd,
  input  logic [1:0]               pipe_wb_sel,
  input  logic [31:0]              pipe_alu,
  input  logic [31:0]              pipe_mem,
  input  logic [31:0]              pipe_pc,
  input  logic                     ll_valid,
  output logic                     ll_ready,
  input  logic [4:0]               ll_rd,
  input  logic [31:0]              ll_data,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wd,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   ll_count
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  wb_req_t       head, ll_req, wr_req;
  logic          fifo_full, fifo_empty;
  logic          push, pop, bypass, force_drain, wr_vld;
  logic [CW-1:0] cnt_q, cnt_d;

  assign ll_req = '{rd: ll_rd, data: ll_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (ll_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (ll_count)
  );

  assign force_drain = !fifo_empty && (cnt_q == MAX_W);

  always_comb begin
    wr_vld     = 1'b0;
    wr_req     = '0;
    pop        = 1'b0;
    bypass     = 1'b0;
    pipe_stall = 1'b0;
    if (rst) begin
      wr_vld = 1'b0;
    end else if (force_drain) begin
      wr_vld     = 1'b1;
      wr_req     = head;
      pop        = 1'b1;
      pipe_stall = 1'b1;
    end else if (pipe_wb_valid) begin
      wr_vld = 1'b1;
      wr_req = '{rd: pipe_rd,
                 data: wb_pipe_value(pipe_wb_sel, pipe_alu, pipe_mem, pipe_pc)};
    end else if (!fifo_empty) begin
      wr_vld = 1'b1;
      wr_req = head;
      pop    = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (ll_valid) begin
      // Idle port and empty FIFO: write the offered result directly, never buffering it.
      wr_vld = 1'b1;
      wr_req = ll_req;
      bypass = 1'b1;
`endif
    end
  end

  // Pushing only when not full means a pop never frees a slot for the same cycle.
  assign ll_ready = !rst && !fifo_full;
  assign push     = ll_valid && ll_ready && !bypass;

  // x0 writes still retire their slot; only the enable is dropped.
  assign rf_we = wr_vld && (wr_req.rd != 5'd0);
  assign rf_wa = wr_req.rd;
  assign rf_wd = wr_req.data;

  always_comb begin
    cnt_d = '0;
    if (pop)              cnt_d = '0;
    else if (!fifo_empty) cnt_d = (cnt_q == MAX_W) ? MAX_W : cnt_q + 1'b1;
    else                  cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with DEPTH=2, MAX_WAIT=4.
// Inputs change on the falling edge; outputs are checked 1ns later, before the next rising edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_rd;
  logic [1:0]  pipe_wb_sel;
  logic [31:0] pipe_alu, pipe_mem, pipe_pc;
  logic        ll_valid, ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pipe_stall;
  logic [1:0]  ll_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_rd       (pipe_rd),
    .pipe_wb_sel   (pipe_wb_sel),
    .pipe_alu      (pipe_alu),
    .pipe_mem      (pipe_mem),
    .pipe_pc       (pipe_pc),
    .ll_valid      (ll_valid),
    .ll_ready      (ll_ready),
    .ll_rd         (ll_rd),
    .ll_data       (ll_data),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .pipe_stall    (pipe_stall),
    .ll_count      (ll_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    pipe_wb_valid = v; pipe_rd = rd; pipe_wb_sel = sel;
    pipe_alu = alu; pipe_mem = mem; pipe_pc = pc;
  endtask

  task automatic ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ll_valid = v; ll_rd = rd; ll_data = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b1, 5'd3, 2'd0, 32'h11, 32'h0, 32'h0);
    ll(1'b1, 5'd4, 32'h22);

    // Reset with both sources active: nothing writes, nothing is accepted.
    cyc(); settle();
    chk("rst_we", rf_we, 0);
    chk("rst_ready", ll_ready, 0);
    chk("rst_stall", pipe_stall, 0);
    cyc(); rst = 1'b0;
    pipe(1'b0, 5'd0, 2'd0, 0, 0, 0); ll(1'b0, 5'd0, 0);
    settle();
    chk("post_rst_count", ll_count, 0);
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_ready", ll_ready, 1);

    // Pipeline-only value mux.
    cyc(); pipe(1'b1, 5'd5, 2'd2, 32'h1, 32'h2, 32'h100); settle();
    chk("pc4_we", rf_we, 1); chk("pc4_wa", rf_wa, 5); chk("pc4_wd", rf_wd, 32'h104);
    cyc(); pipe(1'b1, 5'd6, 2'd1, 32'h1, 32'hDEADBEEF, 32'h100); settle();
    chk("mem_wa", rf_wa, 6); chk("mem_wd", rf_wd, 32'hDEADBEEF);
    cyc(); pipe(1'b1, 5'd7, 2'd0, 32'h1234, 32'h2, 32'h100); settle();
    chk("alu_wd", rf_wd, 32'h1234);
    cyc(); pipe(1'b1, 5'd8, 2'd3, 32'h5678, 32'h2, 32'h100); settle();
    chk("rsvd_wd", rf_wd, 32'h5678);
    cyc(); pipe(1'b1, 5'd9, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFC); settle();
    chk("pc4_wrap_wd", rf_wd, 32'h0);
    cyc(); pipe(1'b1, 5'd0, 2'd0, 32'hAA, 32'h0, 32'h0); settle();
    chk("pipe_x0_we", rf_we, 0);
    chk("pipe_x0_stall", pipe_stall, 0);

    // Bubble drain of a single ll result.
    cyc(); pipe(1'b0, 5'd0, 2'd0, 0, 0, 0); ll(1'b1, 5'd7, 32'h55); settle();
    chk("bub0_ready", ll_ready, 1);
`ifdef WB_BYPASS_EN
    chk("bub0_we", rf_we, 1); chk("bub0_wa", rf_wa, 7); chk("bub0_wd", rf_wd, 32'h55);
    cyc(); ll(1'b0, 5'd0, 0); settle();
    chk("bub1_count", ll_count, 0); chk("bub1_we", rf_we, 0);
`else
    chk("bub0_we", rf_we, 0);
    cyc(); ll(1'b0, 5'd0, 0); settle();
    chk("bub1_count", ll_count, 1);
    chk("bub1_we", rf_we, 1); chk("bub1_wa", rf_wa, 7); chk("bub1_wd", rf_wd, 32'h55);
    cyc(); settle();
    chk("bub2_count", ll_count, 0); chk("bub2_we", rf_we, 0);
`endif

    // Starvation: pipeline busy, one pushed result forces a drain on cycle 5.
    cyc(); pipe(1'b1, 5'd1, 2'd0, 32'hA0, 0, 0); ll(1'b1, 5'd9, 32'h99); settle();
    chk("st0_ready", ll_ready, 1); chk("st0_wa", rf_wa, 1); chk("st0_wd", rf_wd, 32'hA0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); pipe(1'b1, 5'd1, 2'd0, 32'hA0 + i, 0, 0); ll(1'b0, 5'd0, 0); settle();
      chk($sformatf("st%0d_wd", i), rf_wd, 32'hA0 + i);
      chk($sformatf("st%0d_stall", i), pipe_stall, 0);
      chk($sformatf("st%0d_count", i), ll_count, 1);
    end
    cyc(); pipe(1'b1, 5'd1, 2'd0, 32'hA5, 0, 0); settle();
    chk("st5_stall", pipe_stall, 1); chk("st5_we", rf_we, 1);
    chk("st5_wa", rf_wa, 9); chk("st5_wd", rf_wd, 32'h99);
    cyc(); settle();
    chk("st6_stall", pipe_stall, 0); chk("st6_count", ll_count, 0);
    chk("st6_wa", rf_wa, 1); chk("st6_wd", rf_wd, 32'hA5);

    // Full FIFO: third request held until a slot frees, written in push order.
    cyc(); pipe(1'b1, 5'd2, 2'd0, 32'hB0, 0, 0); ll(1'b1, 5'd10, 32'h10A); settle();
    chk("fu0_ready", ll_ready, 1);
    cyc(); ll(1'b1, 5'd11, 32'h10B); settle();
    chk("fu1_ready", ll_ready, 1); chk("fu1_count", ll_count, 1);
    cyc(); ll(1'b1, 5'd12, 32'h10C); settle();
    chk("fu2_ready", ll_ready, 0); chk("fu2_count", ll_count, 2); chk("fu2_wa", rf_wa, 2);
    cyc(); pipe(1'b0, 5'd0, 2'd0, 0, 0, 0); settle();
    chk("fu3_ready", ll_ready, 0); chk("fu3_wa", rf_wa, 10); chk("fu3_wd", rf_wd, 32'h10A);
    cyc(); settle();
    chk("fu4_count", ll_count, 1); chk("fu4_ready", ll_ready, 1);
    chk("fu4_wa", rf_wa, 11); chk("fu4_wd", rf_wd, 32'h10B);
    cyc(); ll(1'b0, 5'd0, 0); settle();
    chk("fu5_count", ll_count, 1); chk("fu5_wa", rf_wa, 12); chk("fu5_wd", rf_wd, 32'h10C);
    cyc(); settle();
    chk("fu6_count", ll_count, 0); chk("fu6_we", rf_we, 0);

    // ll result to x0: slot consumed without a write.
    cyc(); ll(1'b1, 5'd0, 32'h77); settle();
    chk("x0ll0_we", rf_we, 0);
    cyc(); ll(1'b0, 5'd0, 0); settle();
    chk("x0ll1_we", rf_we, 0);
`ifdef WB_BYPASS_EN
    chk("x0ll1_count", ll_count, 0);
`else
    chk("x0ll1_count", ll_count, 1);
    cyc(); settle();
    chk("x0ll2_count", ll_count, 0); chk("x0ll2_we", rf_we, 0);
`endif

    // Reset mid-operation discards two buffered entries.
    cyc(); pipe(1'b1, 5'd3, 2'd0, 32'hC0, 0, 0); ll(1'b1, 5'd13, 32'h13); settle();
    cyc(); ll(1'b1, 5'd14, 32'h14); settle();
    cyc(); rst = 1'b1; ll(1'b1, 5'd15, 32'h15); settle();
    chk("mr_pre_count", ll_count, 2);
    chk("mr_we", rf_we, 0); chk("mr_ready", ll_ready, 0); chk("mr_stall", pipe_stall, 0);
    cyc(); rst = 1'b0; pipe(1'b0, 5'd0, 2'd0, 0, 0, 0); ll(1'b0, 5'd0, 0); settle();
    chk("mr1_count", ll_count, 0); chk("mr1_we", rf_we, 0);
    cyc(); settle();
    chk("mr2_we", rf_we, 0); chk("mr2_count", ll_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
